ps2_keystroke_decoder: RTL and testbench

- Upstream front end of the Enigma datapath.
- Receives raw PS/2 keyboard frames, decodes make codes for letters A–Z into uppercase ASCII, and emits a one-cycle strobe.
- char_out drives the Enigma char_input; char_valid drives char_pressed, which steps the rotor and feeds the letter shifter.
- Break codes, extended keys, non-letter keys and typematic repeats are filtered out, so each physical key press steps the rotor exactly once.

---
 rtl/ps2_keystroke_decoder.sv | 197 +++++++++++++++++++
 tb/tb_ps2_keystroke_decoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_keystroke_decoder.sv
// PS/2 keyboard receiver: turns letter make codes into one-cycle uppercase ASCII strobes.
// Define PS2_PARITY_CHECK_EN to also reject frames whose odd parity is wrong.
module ps2_keystroke_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       frame_error
);

  localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {StIdle, StRecv} rx_state_e;
  typedef enum logic [1:0] {StNormal, StBreak, StExt, StExtBreak} dec_state_e;

  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
    logic [7:0] a;
    case (code)
      8'h1C: a = 8'h41;  8'h32: a = 8'h42;  8'h21: a = 8'h43;  8'h23: a = 8'h44;
      8'h24: a = 8'h45;  8'h2B: a = 8'h46;  8'h34: a = 8'h47;  8'h33: a = 8'h48;
      8'h43: a = 8'h49;  8'h3B: a = 8'h4A;  8'h42: a = 8'h4B;  8'h4B: a = 8'h4C;
      8'h3A: a = 8'h4D;  8'h31: a = 8'h4E;  8'h44: a = 8'h4F;  8'h4D: a = 8'h50;
      8'h15: a = 8'h51;  8'h2D: a = 8'h52;  8'h1B: a = 8'h53;  8'h2C: a = 8'h54;
      8'h3C: a = 8'h55;  8'h2A: a = 8'h56;  8'h1D: a = 8'h57;  8'h22: a = 8'h58;
      8'h35: a = 8'h59;  8'h1A: a = 8'h5A;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  logic [1:0]      clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic            filt_q, filt_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  rx_state_e       rx_state_q, rx_state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  dec_state_e      dec_state_q, dec_state_d;
  logic [7:0]      held_q, held_d;
  logic [7:0]      char_out_q, char_out_d;
  logic            char_valid_q, char_valid_d;
  logic            frame_error_q, frame_error_d;

  logic       fall_edge;
  logic       data_s;
  logic       frame_ok;
  logic       byte_ok;
  logic [7:0] ascii;

  assign data_s = data_sync_q[1];
  assign ascii  = scan_to_ascii(shift_q);

`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = data_s & (^{shift_q, par_q});
`else
  assign frame_ok = data_s;
`endif

  // Synchronizers plus a glitch filter on the PS/2 clock line.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    filt_d      = filt_q;
    filt_cnt_d  = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + FiltW'(1);
      end
    end
  end

  assign fall_edge = filt_q & ~filt_d;

  // Frame receiver; the stop-bit edge evaluates the frame in the same cycle.
  always_comb begin
    rx_state_d    = rx_state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    par_d         = par_q;
    tmo_d         = tmo_q;
    byte_ok       = 1'b0;
    frame_error_d = 1'b0;
    if (fall_edge) begin
      tmo_d = '0;
      unique case (rx_state_q)
        StIdle: begin
          if (!data_s) begin
            rx_state_d = StRecv;
            bit_cnt_d  = 4'd1;
          end
        end
        StRecv: begin
          if (bit_cnt_q <= 4'd8) begin
            shift_d   = {data_s, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (bit_cnt_q == 4'd9) begin
            par_d     = data_s;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            rx_state_d    = StIdle;
            bit_cnt_d     = 4'd0;
            byte_ok       = frame_ok;
            frame_error_d = ~frame_ok;
          end
        end
        default: rx_state_d = StIdle;
      endcase
    end else if (rx_state_q == StRecv) begin
      if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
        rx_state_d    = StIdle;
        bit_cnt_d     = 4'd0;
        tmo_d         = '0;
        frame_error_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
  end

  // Make/break decoder with repeat suppression through held_q.
  always_comb begin
    dec_state_d  = dec_state_q;
    held_d       = held_q;
    char_out_d   = char_out_q;
    char_valid_d = 1'b0;
    if (byte_ok) begin
      unique case (dec_state_q)
        StNormal: begin
          if (shift_q == 8'hF0) begin
            dec_state_d = StBreak;
          end else if (shift_q == 8'hE0) begin
            dec_state_d = StExt;
          end else if (ascii != 8'h00 && shift_q != held_q) begin
            char_out_d   = ascii;
            char_valid_d = 1'b1;
            held_d       = shift_q;
          end
        end
        StBreak: begin
          if (shift_q == held_q) held_d = 8'h00;
          dec_state_d = StNormal;
        end
        StExt:      dec_state_d = (shift_q == 8'hF0) ? StExtBreak : StNormal;
        StExtBreak: dec_state_d = StNormal;
        default:    dec_state_d = StNormal;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q    <= 2'b11;
      data_sync_q   <= 2'b11;
      filt_q        <= 1'b1;
      filt_cnt_q    <= '0;
      rx_state_q    <= StIdle;
      bit_cnt_q     <= 4'd0;
      shift_q       <= 8'h00;
      par_q         <= 1'b0;
      tmo_q         <= '0;
      dec_state_q   <= StNormal;
      held_q        <= 8'h00;
      char_out_q    <= 8'h00;
      char_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      clk_sync_q    <= clk_sync_d;
      data_sync_q   <= data_sync_d;
      filt_q        <= filt_d;
      filt_cnt_q    <= filt_cnt_d;
      rx_state_q    <= rx_state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      tmo_q         <= tmo_d;
      dec_state_q   <= dec_state_d;
      held_q        <= held_d;
      char_out_q    <= char_out_d;
      char_valid_q  <= char_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign char_out    = char_out_q;
  assign char_valid  = char_valid_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_keystroke_decoder.sv
// Self-checking bench: bit-banged PS/2 frames, a reference decoder feeding a strobe scoreboard.
module tb_ps2_keystroke_decoder;

  localparam int unsigned FilterLen = 8;
  localparam int unsigned Timeout   = 2000;
  localparam int          Half      = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] char_out;
  logic       char_valid;
  logic       frame_error;

  ps2_keystroke_decoder #(
    .FILTER_LEN     (FilterLen),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .char_out    (char_out),
    .char_valid  (char_valid),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [7:0] ch;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  // Reference decoder state
  int         m_state = 0;
  logic [7:0] m_held  = 8'h00;
  logic [7:0] m_last  = 8'h00;

  logic [7:0] codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                             8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                             8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_ascii(input logic [7:0] b);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 26; i++) if (codes[i] == b) r = 8'h41 + 8'(i);
    return r;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] a;
    exp_t e;
    case (m_state)
      0: begin
        if (b == 8'hF0) m_state = 1;
        else if (b == 8'hE0) m_state = 2;
        else begin
          a = ref_ascii(b);
          if (a != 8'h00 && b != m_held) begin
            e.err = 1'b0;
            e.ch  = a;
            exp_q.push_back(e);
            m_held = b;
            m_last = a;
          end
        end
      end
      1: begin
        if (b == m_held) m_held = 8'h00;
        m_state = 0;
      end
      2: m_state = (b == 8'hF0) ? 3 : 0;
      default: m_state = 0;
    endcase
  endtask

  task automatic push_err();
    exp_t e;
    e.err = 1'b1;
    e.ch  = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (Half) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (Half) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    bit rejected;
    rejected = bad_stop;
`ifdef PS2_PARITY_CHECK_EN
    rejected = rejected | bad_par;
`endif
    if (rejected) push_err();
    else model_byte(b);
    send_bits(b, bad_par, bad_stop, 11);
    ps2_data = 1'b1;
    repeat (2 * Half) @(negedge clk);
    chk($sformatf("hold_%02h", b), {24'h0, char_out}, {24'h0, m_last});
  endtask

  // Strobe monitor: every strobe must match the head of the scoreboard.
  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (char_valid || frame_error)) begin
      chk("excl", {31'h0, char_valid & frame_error}, 32'h0);
      if (prev_strobe) chk("width", 32'h1, 32'h0);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {30'h0, frame_error, char_valid}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("kind", {31'h0, frame_error}, {31'h0, e.err});
        if (!e.err) chk("char", {24'h0, char_out}, {24'h0, e.ch});
      end
    end
    prev_strobe = char_valid | frame_error;
  end

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_char", {24'h0, char_out}, 32'h0);
    chk("rst_valid", {31'h0, char_valid}, 32'h0);
    chk("rst_err", {31'h0, frame_error}, 32'h0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    send_byte(8'h1C, 0, 0);
    send_byte(8'h1C, 0, 0);
    send_byte(8'h1C, 0, 0);
    send_byte(8'hF0, 0, 0);
    send_byte(8'h1C, 0, 0);
    send_byte(8'h1C, 0, 0);

    send_byte(8'hE0, 0, 0);
    send_byte(8'h75, 0, 0);
    send_byte(8'hE0, 0, 0);
    send_byte(8'hF0, 0, 0);
    send_byte(8'h75, 0, 0);
    send_byte(8'h29, 0, 0);
    send_byte(8'h15, 0, 0);

    send_byte(8'h2D, 0, 1);
    send_byte(8'h2D, 0, 0);

    send_byte(8'h1A, 1, 0);

    // Truncated frame left idle until the receiver times out.
    push_err();
    send_bits(8'h1B, 0, 0, 5);
    ps2_data = 1'b1;
    repeat (Timeout + 100) @(negedge clk);
    chk("timeout_drained", exp_q.size(), 32'h0);
    send_byte(8'h1B, 0, 0);

    // Reset in the middle of a frame.
    send_bits(8'h2C, 0, 0, 4);
    ps2_data = 1'b1;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_char", {24'h0, char_out}, 32'h0);
    chk("midrst_valid", {31'h0, char_valid}, 32'h0);
    reset   = 1'b0;
    m_state = 0;
    m_held  = 8'h00;
    m_last  = 8'h00;
    repeat (2 * Half) @(negedge clk);
    send_byte(8'h1C, 0, 0);

    repeat (100) @(negedge clk);
    chk("drain", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
